pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined MIPS core, sitting at the head of the IF stage.
- Owns the PC register and produces the sequential and link addresses PC+4 and PC+8.
- Arbitrates next-PC between sequential flow, branch/jump redirect, exception entry and eret.
- Holds a redirect that arrives during a stall until the stall releases, so no control transfer is lost.

Parameters:
- WIDTH, 32, PC width in bits (>= 8).
- RESET_PC, 32'h0000_3000, PC value loaded on reset (truncated to WIDTH).
- EXC_VEC, 32'h0000_4180, exception entry address.
- STEP, 4, sequential increment in bytes; link output is 2*STEP.
- IM_BASE, 32'h0000_3000, lowest legal fetch address (used only with the optional feature).
- IM_BYTES, 32'h0000_1000, size of legal fetch window in bytes (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from ID; PC holds while high.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  WIDTH  branch/jump target.
- exc_req  input  1  exception/interrupt entry request from CP0.
- eret_req  input  1  return-from-exception request.
- epc  input  WIDTH  return address for eret.
- pc  output  WIDTH  current fetch address (registered).
- pc_plus4  output  WIDTH  pc + STEP (combinational).
- pc_plus8  output  WIDTH  pc + 2*STEP (combinational; jal/jalr link value).
- pending  output  1  a redirect captured during stall is waiting (registered).
- fetch_adel  output  1  fetch address error: pc[1:0] != 0.
- fetch_oor  output  1  fetch out of range; driven only with PC_RANGE_CHECK_EN, else tied 0.

Behaviour:
- Reset state:
  - reset = 1 on a rising edge: pc <= RESET_PC, pending <= 0, pend_target <= 0, state <= RUN.
  - The next edge with reset low resumes normal operation.
  - Reset takes priority over every other input.
- State machine:
  - States: RUN (pending = 0) and HOLD (pending = 1).
  - `pending` is the registered state bit.
- Per-edge priority when reset = 0, highest first:
  1. exc_req: pc <= EXC_VEC; pending cleared; this wins over stall and over any live or pending redirect.
  2. eret_req: pc <= epc; pending cleared; this ignores stall.
  3. stall = 1: pc holds. If redirect_valid, pend_target <= redirect_target and state <= HOLD; a later redirect while still stalled overwrites it (latest wins). If redirect_valid = 0, the state is unchanged.
  4. stall = 0 and redirect_valid: pc <= redirect_target; state <= RUN. A live redirect beats a pending one.
  5. stall = 0 and state HOLD: pc <= pend_target; state <= RUN.
  6. Otherwise: pc <= pc + STEP.
- Latency: a redirect with stall = 0 is visible on pc the cycle after it is asserted. A held redirect is visible the cycle after stall falls.
- Arithmetic:
  - All adds are modulo 2^WIDTH; wrap-around is silent. Example: WIDTH = 32, pc = 32'hFFFF_FFFC gives next pc = 0 and pc_plus8 = 4.
  - Targets and epc are used unmodified; no alignment masking.
- Error flags:
  - fetch_adel is combinational from the registered pc.
  - The block only flags; it never redirects on error. CP0 decides whether to raise exc_req.
- Simultaneous exc_req and eret_req: exc_req wins.

Optional Feature:
- Macro: PC_RANGE_CHECK_EN.
- Defined: fetch_oor = 1 when pc < IM_BASE or pc >= IM_BASE + IM_BYTES. The comparison is unsigned at WIDTH+1 bits so the end of the window does not overflow. The flag is combinational from pc.
- Not defined: fetch_oor is tied to 0, and no comparator logic is generated.

Decomposition:
- Package pc_gen_pkg holds:
  - default RESET_PC, EXC_VEC, IM_BASE, IM_BYTES constants;
  - the RUN/HOLD state encoding typedef;
  - the STEP default.
- One sub-module, pc_adder (parameters WIDTH and INC; out = in + INC, modulo 2^WIDTH). It is instantiated twice, for pc_plus4 and pc_plus8, and pc_plus4 also feeds the sequential next-PC mux.

Test Plan:
- Reset, then 3 free-running cycles: pc sequence 0x3000, 0x3004, 0x3008, 0x300C; pc_plus8 = 0x3014 in the last cycle.
- Redirect during stall: stall = 1 for 3 cycles, with redirect_valid to 0x3400 in cycle 1 and to 0x3500 in cycle 2. Required: pc holds and pending = 1; after stall falls, pc = 0x3500 and pending = 0.
- HOLD with a live redirect to 0x3600 on the first unstalled cycle: pc = 0x3600 (live wins) and pending cleared.
- exc_req with stall = 1, pending = 1 and redirect_valid = 1: next pc = 0x4180 and pending = 0. Then eret_req with epc = 0x3010: next pc = 0x3010.
- Wrap and alignment: force a redirect to 0xFFFF_FFFC, then run: pc = 0 on the next edge. A redirect to 0x3002 gives fetch_adel = 1 while pc = 0x3002.
- With PC_RANGE_CHECK_EN: redirect to 0x4000 gives fetch_oor = 1, and 0x3FFC gives 0. Without the macro, fetch_oor stays 0 for both.
- Reset asserted while in HOLD: pc = 0x3000 and pending = 0 on the next edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared defaults and state encoding for the IF-stage PC generator.
//   DEF_RESET_PC / DEF_EXC_VEC  : reset and exception entry addresses
//   DEF_IM_BASE / DEF_IM_BYTES  : legal fetch window (range-check build only)
//   DEF_STEP                    : sequential fetch increment in bytes
//   pc_state_e                  : RUN (no redirect waiting) / HOLD (redirect parked)
package pc_gen_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BYTES = 32'h0000_1000;
  localparam int          DEF_STEP     = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_adder.sv
// pc_adder: constant-increment adder, sum_o = a_i + INC modulo 2^WIDTH.
//   a_i   : operand
//   sum_o : operand plus INC, wrapping silently
module pc_adder #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  assign sum_o = a_i + INC_W;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of the IF stage.
// Owns the PC register, produces PC+STEP / PC+2*STEP, and arbitrates the next
// PC between exception entry, eret, branch/jump redirect and sequential flow.
// A redirect arriving while stalled is parked and applied when the stall drops.
//
// Ports:
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   stall             : PC holds while high (exception and eret still apply)
//   redirect_valid    : branch/jump taken, target in redirect_target
//   exc_req           : exception entry, jump to EXC_VEC
//   eret_req / epc    : return from exception to epc
//   pc                : registered fetch address
//   pc_plus4/pc_plus8 : pc + STEP, pc + 2*STEP (link value)
//   pending           : registered, a parked redirect is waiting
//   fetch_adel        : pc not word aligned
//   fetch_oor         : pc outside [IM_BASE, IM_BASE+IM_BYTES)
//
// Optional build macro PC_RANGE_CHECK_EN: enables the fetch_oor comparator;
// without it fetch_oor is tied low.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
  parameter int          STEP     = DEF_STEP,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter logic [31:0] IM_BYTES = DEF_IM_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_plus8,
  output logic             pending,
  output logic             fetch_adel,
  output logic             fetch_oor
);

  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_VEC_W  = WIDTH'(EXC_VEC);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  pc_adder #(.WIDTH(WIDTH), .INC(STEP)) u_add_step (
    .a_i   (pc_q),
    .sum_o (pc_plus4)
  );

  pc_adder #(.WIDTH(WIDTH), .INC(2 * STEP)) u_add_link (
    .a_i   (pc_q),
    .sum_o (pc_plus8)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC_W;
      state_q    <= RUN;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Exception and eret override the stall: they flush the front end, so any
  // parked redirect belongs to squashed instructions and is dropped.
  always_comb begin
    pc_d       = pc_plus4;
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_req) begin
      pc_d    = EXC_VEC_W;
      state_d = RUN;
    end else if (eret_req) begin
      pc_d    = epc;
      state_d = RUN;
    end else if (stall) begin
      pc_d = pc_q;
      if (redirect_valid) begin
        // Latest redirect during a stall overwrites any earlier one.
        pend_tgt_d = redirect_target;
        state_d    = HOLD;
      end
    end else if (redirect_valid) begin
      // A live redirect comes from a younger branch decision than the parked one.
      pc_d    = redirect_target;
      state_d = RUN;
    end else if (state_q == HOLD) begin
      pc_d    = pend_tgt_q;
      state_d = RUN;
    end
  end

  assign pc         = pc_q;
  assign pending    = (state_q == HOLD);
  assign fetch_adel = (pc_q[1:0] != 2'b00);

`ifdef PC_RANGE_CHECK_EN
  // One extra bit so IM_BASE + IM_BYTES cannot wrap at the top of the space.
  localparam logic [WIDTH:0] WIN_LO = {1'b0, WIDTH'(IM_BASE)};
  localparam logic [WIDTH:0] WIN_HI = WIN_LO + {1'b0, WIDTH'(IM_BYTES)};

  assign fetch_oor = ({1'b0, pc_q} < WIN_LO) || ({1'b0, pc_q} >= WIN_HI);
`else
  assign fetch_oor = 1'b0;
`endif

endmodule
